tick_gen: RTL
=============

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter: NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter: DIV_W, default 16, width of each channel's divisor and counter.
REQ-003 Parameter: DEFAULT_DIV, default 10, divisor loaded into every channel at reset (0..2^DIV_W-1).
REQ-004 Port: clk_in  input  1  single system clock; all logic on its rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: en  input  1  global count enable; low freezes all channels.
REQ-007 Port: sync  input  1  one-cycle pulse; realigns all channels to phase 0.
REQ-008 Port: load_valid  input  1  divisor-load request.
REQ-009 Port: load_ch  input  log2(NUM_CH) (min 1)  target channel of load.
REQ-010 Port: load_div  input  DIV_W  new divisor for load_ch.
REQ-011 Port: load_ready  output  1  high when the single pending-load slot is empty.
REQ-012 Port: tick  output  NUM_CH  per-channel one-cycle strobe, once per period.
REQ-013 Port: clk_out  output  NUM_CH  per-channel square-wave, registered, glitch-free.

Function
REQ-014 Each channel SHALL hold div[i] and cnt[i]; with en=1 and div[i]>=1, cnt[i] counts 0..div[i]-1 and wraps to 0.
REQ-015 tick[i] SHALL be registered and asserted for exactly the cycle after the edge on which cnt[i] wraps from div[i]-1 to 0; with div[i]=1, tick[i] stays high continuously.
REQ-016 clk_out[i] SHALL be registered and equal (next cnt[i] < ceil(div[i]/2)): high ceil(div/2) cycles, low floor(div/2) cycles; div=1 gives constant 1.
REQ-017 div[i]=0 SHALL disable channel i: cnt[i] held 0, tick[i]=0, clk_out[i]=0.
REQ-018 en=0 SHALL hold every cnt and clk_out value and force tick=0; counting resumes from the held value when en returns to 1.
REQ-019 A load SHALL be accepted on a cycle with load_valid=1 and load_ready=1; load_ch and load_div are captured into the pending slot and load_ready drops the next cycle.
REQ-020 A pending load SHALL be applied to div[load_ch] on the edge where that channel wraps, so the period in progress completes with the old divisor.
REQ-021 If the target channel's div is 0, the pending load SHALL be applied on the next edge regardless of en.
REQ-022 load_ch >= NUM_CH SHALL be accepted and discarded, leaving all divisors unchanged.
REQ-023 load_ready SHALL return high on the cycle after the pending load is applied or discarded.
REQ-024 sync=1 SHALL, on the next edge, clear every cnt to 0, force tick=0 that cycle, and apply any pending load immediately; sync overrides en=0 and a simultaneous wrap.
REQ-025 A load accepted on the same edge a wrap occurs on its target channel SHALL apply at the following wrap, not the current one.

Reset
REQ-026 On rst=1 at a rising edge: div[i]=DEFAULT_DIV, cnt[i]=0, tick=0, clk_out[i]=(DEFAULT_DIV>=1), pending slot emptied, load_ready=1.
REQ-027 rst SHALL dominate sync, en and loads; a load pending at reset is discarded.
REQ-028 With en=1, the first tick after reset release SHALL occur exactly DEFAULT_DIV cycles later, then every DEFAULT_DIV cycles.

Structure
REQ-029 A shared package tick_gen_pkg SHALL hold the DIV_W default, the channel-index width function, and the half-period (ceil(div/2)) helper.
REQ-030 The channel counter/tick/clk_out logic SHALL be one sub-module, tick_gen_ch, instantiated NUM_CH times; the load slot and sync fan-out stay in tick_gen.

Verification (NUM_CH=2, DIV_W=16, DEFAULT_DIV=10)
REQ-031 Release rst, en=1 -> tick[0], tick[1] high at cycles 10, 20, 30; clk_out 5 high / 5 low; load_ready=1.
REQ-032 Load ch1 div=3 when cnt[1]=4 -> current 10-cycle period finishes, then tick[1] every 3 cycles (clk_out 2 high / 1 low); load_ready low until applied; ch0 unaffected.
REQ-033 Load ch0 div=0, then div=7 -> ch0 silent with clk_out=0 after its wrap; second load applies next edge and the first tick follows 7 cycles later.
REQ-034 Pulse sync at cnt=6 with a load ch1 div=5 pending -> all cnt=0, no tick that cycle, ch1 period 5 immediately, ch0 next tick 10 cycles later.
REQ-035 Drop en for 5 cycles mid-period -> that period stretches to 15 cycles, tick=0 and clk_out frozen while en=0.
REQ-036 Load ch1 div=5 then assert rst before its wrap -> pending load discarded, div=10 on both channels, load_ready=1.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared defaults and helpers for the tick generator
package tick_gen_pkg;
    localparam int DIV_W_DEF = 16;
    function automatic int ch_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic logic [31:0] half_period(input logic [31:0] d);
        return (d >> 1) + {31'd0, d[0]};
    endfunction
endpackage

// File: rtl/tick_gen_ch.sv
// tick_gen_ch: one divider channel with tick strobe and square-wave output
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load_req,
    input  logic [DIV_W-1:0] load_div,
    output logic             take,
    output logic             tick,
    output logic             clk_out
);
    logic [DIV_W-1:0] div, cnt, div_nx, cnt_nx;
    logic idle, wrap, restart, clk_nx;
    always_comb begin
        idle    = div == '0;
        wrap    = en && !idle && cnt == div - 1'b1;
        restart = sync || idle || wrap;
        take    = load_req && restart;
        div_nx  = take ? load_div : div;
        cnt_nx  = restart ? '0 : en ? cnt + 1'b1 : cnt;
        clk_nx  = (en || restart) ? 32'(cnt_nx) < half_period(32'(div_nx)) : clk_out;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= DIV_W'(DEFAULT_DIV);
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= DEFAULT_DIV != 0;
        end else begin
            div     <= div_nx;
            cnt     <= cnt_nx;
            tick    <= wrap && !sync;
            clk_out <= clk_nx;
        end
    end
endmodule

// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable tick/clock divider with a one-deep load slot
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 10,
    localparam int CH_W       = ch_w(NUM_CH)
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              load_valid,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [DIV_W-1:0]  load_div,
    output logic              load_ready,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);
    logic              pend_valid, bad_ch;
    logic [CH_W-1:0]   pend_ch;
    logic [DIV_W-1:0]  pend_div;
    logic [NUM_CH-1:0] take;
    assign load_ready = !pend_valid;
    assign bad_ch     = int'(pend_ch) >= NUM_CH;
    always_ff @(posedge clk_in) begin
        if (rst) pend_valid <= 1'b0;
        else if (pend_valid) begin
            if (|take || bad_ch) pend_valid <= 1'b0;
        end else if (load_valid) begin
            pend_valid <= 1'b1;
            pend_ch    <= load_ch;
            pend_div   <= load_div;
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_gen_ch #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
            .clk     (clk_in),
            .rst     (rst),
            .en      (en),
            .sync    (sync),
            .load_req(pend_valid && int'(pend_ch) == i),
            .load_div(pend_div),
            .take    (take[i]),
            .tick    (tick[i]),
            .clk_out (clk_out[i])
        );
    end
endmodule
